// File: rtl/spi_command_decoder_if.sv
// SPI word path and payload FIFO drain port of the command decoder.
// The decoder takes the slave view; the SPI block and the consumer take the master view.
interface spi_command_decoder_if #(
    parameter int WordBits = 8
);
    logic                cs;
    logic                word_ready;
    logic [WordBits-1:0] data_word_received;
    logic [WordBits-1:0] data_word_to_send;
    logic [WordBits-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    modport slave (
        input  cs,
        input  word_ready,
        input  data_word_received,
        input  out_ready,
        output data_word_to_send,
        output out_data,
        output out_valid
    );

    modport master (
        output cs,
        output word_ready,
        output data_word_received,
        output out_ready,
        input  data_word_to_send,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/spi_command_decoder.sv
// SPI frame command decoder: WRITE payload goes to a first-word-fall-through FIFO.
// It also drives a live status word, {overflow, bad_cmd, fill count}, back to the SPI block.
module spi_command_decoder #(
    parameter int WordBits  = 8,
    parameter int FifoDepth = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_command_decoder_if.slave bus
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;

    localparam logic [WordBits-1:0] CmdNop   = '0;
    localparam logic [WordBits-1:0] CmdWrite = WordBits'(1);
    localparam logic [WordBits-1:0] CmdClear = WordBits'(2);

    typedef enum logic [1:0] {
        START   = 2'd0,
        WRITE   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WordBits-1:0] mem_q [FifoDepth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                bad_q, bad_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic flush;
    logic ovf_set;
    logic bad_set;
    logic word_v;

    logic [WordBits-3:0] count_ext;

    assign full   = (count_q == CntW'(FifoDepth));
    assign empty  = (count_q == '0);
    assign pop    = !empty && bus.out_ready;
    assign word_v = bus.word_ready && !bus.cs;

    // Status reflects registered state only, so the SPI block sees pre-update values.
    assign count_ext             = (WordBits-2)'(count_q);
    assign bus.data_word_to_send = {ovf_q, bad_q, count_ext};
    assign bus.out_data          = mem_q[rd_ptr_q];
    assign bus.out_valid         = !empty;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        flush   = 1'b0;
        ovf_set = 1'b0;
        bad_set = 1'b0;
        if (bus.cs) begin
            state_d = START;
        end else if (word_v) begin
            case (state_q)
                START: begin
                    unique case (1'b1)
                        (bus.data_word_received == CmdWrite): begin
                            state_d = WRITE;
                        end
                        (bus.data_word_received == CmdClear): begin
                            flush   = 1'b1;
                            state_d = DISCARD;
                        end
                        (bus.data_word_received == CmdNop): begin
                            state_d = DISCARD;
                        end
                        default: begin
                            bad_set = 1'b1;
                            state_d = DISCARD;
                        end
                    endcase
                end
                WRITE: begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                DISCARD: begin
                    state_d = DISCARD;
                end
                default: begin
                    state_d = START;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | ovf_set;
        bad_d    = bad_q | bad_set;
        // A flush overrides a same-cycle pop; no push can coincide with it.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            bad_d    = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q + PtrW'(push);
            rd_ptr_d = rd_ptr_q + PtrW'(pop);
            count_d  = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= START;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            bad_q    <= bad_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data_word_received;
        end
    end
endmodule

// File: tb/tb_spi_command_decoder.sv
// Directed bench for spi_command_decoder with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_spi_command_decoder;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    spi_command_decoder_if #(.WordBits(8)) bus ();

    spi_command_decoder #(
        .WordBits (8),
        .FifoDepth(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        bus.data_word_received = w;
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
        tick();
    endtask

    task automatic frame_start();
        bus.cs = 1'b0;
        tick();
    endtask

    task automatic frame_end();
        bus.cs = 1'b1;
        tick();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.cs = 1'b1;
        bus.word_ready = 1'b0;
        bus.data_word_received = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_status", 32'(bus.data_word_to_send), 32'h00);

        // Basic write frame
        frame_start();
        send_word(8'h01);
        chk("cmd_not_pushed", 32'(bus.out_valid), 32'd0);
        bus.data_word_received = 8'hA5;
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
        chk("push_latency", 32'(bus.out_valid), 32'd1);
        chk("push_status", 32'(bus.data_word_to_send), 32'h01);
        tick();
        send_word(8'h3C);
        chk("two_stored", 32'(bus.data_word_to_send), 32'h02);
        frame_end();
        pop_check("pop_a5", 8'hA5);
        pop_check("pop_3c", 8'h3C);
        chk("drained_valid", 32'(bus.out_valid), 32'd0);
        chk("drained_status", 32'(bus.data_word_to_send), 32'h00);

        // Overflow: 18 payload bytes into 16 entries
        frame_start();
        send_word(8'h01);
        for (int i = 1; i <= 18; i++) send_word(8'(i));
        frame_end();
        chk("ovf_status", 32'(bus.data_word_to_send), 32'h90);
        for (int i = 1; i <= 16; i++) pop_check("ovf_drain", 8'(i));
        chk("ovf_empty", 32'(bus.out_valid), 32'd0);
        chk("ovf_sticky", 32'(bus.data_word_to_send), 32'h80);
        frame_start();
        send_word(8'h02);
        frame_end();
        chk("clear_ovf", 32'(bus.data_word_to_send), 32'h00);

        // Bad command
        frame_start();
        send_word(8'h7E);
        send_word(8'h11);
        frame_end();
        chk("bad_nopush", 32'(bus.out_valid), 32'd0);
        frame_start();
        send_word(8'h00);
        frame_end();
        chk("bad_status", 32'(bus.data_word_to_send), 32'h40);
        frame_start();
        send_word(8'h02);
        frame_end();
        frame_start();
        send_word(8'h00);
        frame_end();
        chk("bad_cleared", 32'(bus.data_word_to_send), 32'h00);

        // CLEAR coincident with a pop
        frame_start();
        send_word(8'h01);
        for (int i = 0; i < 5; i++) send_word(8'(8'h21 + i));
        frame_end();
        chk("five_stored", 32'(bus.data_word_to_send), 32'h05);
        frame_start();
        bus.data_word_received = 8'h02;
        bus.word_ready = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_count", 32'(bus.data_word_to_send), 32'h00);
        frame_end();

        // Alternating push and push+pop
        frame_start();
        send_word(8'h01);
        bus.word_ready = 1'b1;
        bus.data_word_received = 8'hB0;
        tick();
        bus.data_word_received = 8'hB1;
        chk("alt_head0", 32'(bus.out_data), 32'hB0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.data_word_received = 8'hB2;
        tick();
        bus.data_word_received = 8'hB3;
        chk("alt_head1", 32'(bus.out_data), 32'hB1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.word_ready = 1'b0;
        chk("alt_count", 32'(bus.data_word_to_send), 32'h02);
        pop_check("alt_b2", 8'hB2);
        pop_check("alt_b3", 8'hB3);
        frame_end();

        // cs raised mid-WRITE; cs beats word_ready
        frame_start();
        send_word(8'h01);
        send_word(8'h61);
        send_word(8'h62);
        bus.cs = 1'b1;
        bus.data_word_received = 8'h63;
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
        tick();
        chk("cs_prio", 32'(bus.data_word_to_send), 32'h02);
        frame_start();
        send_word(8'h00);
        send_word(8'h55);
        frame_end();
        chk("nop_nopush", 32'(bus.data_word_to_send), 32'h02);
        pop_check("cs_61", 8'h61);
        pop_check("cs_62", 8'h62);

        // Reset mid-frame
        frame_start();
        send_word(8'h01);
        for (int i = 0; i < 3; i++) send_word(8'(8'h71 + i));
        chk("pre_rst", 32'(bus.data_word_to_send), 32'h03);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_status", 32'(bus.data_word_to_send), 32'h00);
        send_word(8'h01);
        chk("rst_cmd_nopush", 32'(bus.out_valid), 32'd0);
        send_word(8'h88);
        frame_end();
        chk("rst_new_write", 32'(bus.data_word_to_send), 32'h01);
        pop_check("rst_88", 8'h88);
        chk("final_empty", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
